// File: rtl/ram_pkg.sv
// Shared sizing constants and FSM state encoding for the RAM line packer.
package ram_pkg;
  localparam int BEAT_W = 512;
  localparam int BEATS  = 8;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LINE_W = BEAT_W * BEATS;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } state_t;
endpackage

// File: rtl/ram_line_assembler.sv
// Slot buffer for one RAM line: drops each accepted beat into the next slot,
// and returns to an all-zero line with slot 0 next whenever it is cleared.
module ram_line_assembler #(
  parameter int BEAT_W = ram_pkg::BEAT_W,
  parameter int BEATS  = ram_pkg::BEATS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BEAT_W-1:0]       beat,
  input  logic                    accept,
  input  logic                    clear,
  output logic [BEAT_W*BEATS-1:0] line,
  output logic                    at_last_slot
);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0] beat_cnt;

  // Clearing after every write keeps unused slots of a short line at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_cnt <= '0;
      line     <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
      for (int i = 0; i < BEATS; i++) begin
        if (beat_cnt == CNT_W'(i)) line[i*BEAT_W +: BEAT_W] <= beat;
      end
    end
  end

  assign at_last_slot = (beat_cnt == CNT_W'(BEATS - 1));
endmodule

// File: rtl/ram_line_packer.sv
// Packs input beats into RAM lines and tracks write/read pointers and occupancy
// of a line ring shared with a downstream consumer.
//   state | meaning
//   FILL  | accepting beats into the slot buffer
//   WRITE | one-cycle RAM write of the assembled line
//   STALL | ring full, waiting for the consumer to free a line
module ram_line_packer #(
  parameter int BEAT_W = ram_pkg::BEAT_W,
  parameter int BEATS  = ram_pkg::BEATS,
  parameter int DEPTH  = ram_pkg::DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BEAT_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [ADDR_W-1:0]       ram_wr_address,
  output logic [BEAT_W*BEATS-1:0] ram_wr_data,
  output logic                    wr_val,
  output logic [ADDR_W-1:0]       ram_rd_address,
  input  logic                    line_consumed,
  output logic [ADDR_W:0]         occupancy,
  output logic                    full
);
  localparam int OCC_W = ADDR_W + 1;

  import ram_pkg::*;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [OCC_W-1:0]  occ_next;
  logic              accept;
  logic              write_now;
  logic              consume;
  logic              at_last_slot;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign write_now = (state == WRITE);
  assign in_ready  = (state == FILL) && !rst;
  assign accept    = in_valid && in_ready;
  assign consume   = line_consumed && (occupancy != '0);

  always_comb begin
    occ_next = occupancy;
    if (write_now && !consume) occ_next = occupancy + 1'b1;
    else if (!write_now && consume) occ_next = occupancy - 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (accept && (in_last || at_last_slot)) state_next = WRITE;
      WRITE:   state_next = (occ_next == OCC_W'(DEPTH)) ? STALL : FILL;
      // Leaving on the consuming edge makes in_ready rise the cycle after the pulse.
      STALL:   if (occ_next != OCC_W'(DEPTH)) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FILL;
      wr_ptr         <= '0;
      ram_rd_address <= '0;
      occupancy      <= '0;
    end else begin
      state     <= state_next;
      occupancy <= occ_next;
      if (write_now) wr_ptr <= ptr_inc(wr_ptr);
      if (consume) ram_rd_address <= ptr_inc(ram_rd_address);
    end
  end

  ram_line_assembler #(
    .BEAT_W(BEAT_W),
    .BEATS (BEATS)
  ) u_assembler (
    .clk         (clk),
    .rst         (rst),
    .beat        (in_data),
    .accept      (accept),
    .clear       (write_now),
    .line        (ram_wr_data),
    .at_last_slot(at_last_slot)
  );

  assign ram_wr_address = wr_ptr;
  assign wr_val         = write_now && !rst;
  assign full           = (occupancy == OCC_W'(DEPTH));
endmodule

// File: tb/tb_ram_line_packer.sv
// Randomized and directed bench for ram_line_packer with a queue-based line model.
module tb_ram_line_packer;
  import ram_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [BEAT_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_wr_address;
  logic [LINE_W-1:0] ram_wr_data;
  logic              wr_val;
  logic [ADDR_W-1:0] ram_rd_address;
  logic              line_consumed = 1'b0;
  logic [ADDR_W:0]   occupancy;
  logic              full;

  int tests = 0;
  int fails = 0;

  ram_line_packer dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .ram_wr_address(ram_wr_address),
    .ram_wr_data   (ram_wr_data),
    .wr_val        (wr_val),
    .ram_rd_address(ram_rd_address),
    .line_consumed (line_consumed),
    .occupancy     (occupancy),
    .full          (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_slot(input string name, input int slot,
                          input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s slot %0d: got %h expected %h at %0t", name, slot, act, exp, $time);
    end
  endtask

  // Model: beats collected so far, a pending write, a blocked flag, ring counters.
  logic [BEAT_W-1:0] m_beats[$];
  bit m_ok = 0, m_wp = 0, m_blk = 0;
  bit m_wrote, m_cons, m_acc;
  int m_occ = 0, m_wa = 0, m_ra = 0;
  logic [LINE_W-1:0] m_line;

  always @(posedge clk) begin
    if (rst) begin
      m_beats.delete();
      m_ok = 1; m_wp = 0; m_blk = 0;
      m_occ = 0; m_wa = 0; m_ra = 0;
    end else if (m_ok) begin
      m_wrote = m_wp;
      m_cons  = line_consumed && (m_occ > 0);
      m_acc   = in_valid && !m_wp && !m_blk;
      if (m_wrote) begin
        m_wa = (m_wa + 1) % DEPTH;
        m_occ++;
        m_beats.delete();
      end
      if (m_cons) begin
        m_ra = (m_ra + 1) % DEPTH;
        m_occ--;
      end
      if (m_wrote) begin
        m_wp  = 0;
        m_blk = (m_occ == DEPTH);
      end else if (m_blk) begin
        m_blk = (m_occ == DEPTH);
      end else if (m_acc) begin
        m_beats.push_back(in_data);
        if (m_beats.size() == BEATS || in_last) m_wp = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("in_ready", in_ready, !rst && !m_wp && !m_blk);
      chk("wr_val", wr_val, m_wp && !rst);
      chk("occupancy", occupancy, m_occ);
      chk("full", full, m_occ == DEPTH);
      chk("rd_addr", ram_rd_address, m_ra);
      if (m_wp && !rst) begin
        m_line = '0;
        foreach (m_beats[i]) m_line[i*BEAT_W +: BEAT_W] = m_beats[i];
        chk("wr_addr", ram_wr_address, m_wa);
        for (int s = 0; s < BEATS; s++)
          chk_slot("wr_data", s, ram_wr_data[s*BEAT_W +: BEAT_W], m_line[s*BEAT_W +: BEAT_W]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BEAT_W-1:0] rand_beat();
    logic [BEAT_W-1:0] b;
    for (int i = 0; i < BEAT_W / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic send_beat(input logic [BEAT_W-1:0] d, input bit last);
    bit rdy;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    do begin
      rdy = in_ready;
      step();
      n++;
    end while (!rdy && n < 3000);
    chk("beat_accepted", rdy, 1'b1);
    in_last = 1'b0;
  endtask

  task automatic send_line(input int base);
    for (int i = 0; i < BEATS; i++) send_beat(BEAT_W'(base + i), 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic consume_one();
    line_consumed = 1'b1;
    step();
    line_consumed = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    line_consumed = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_wr_val", wr_val, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_occ", occupancy, 0);
  endtask

  logic [BEAT_W-1:0] a_beat, b_beat, c_beat;

  initial begin
    do_reset();

    // Eight back-to-back beats 0..7.
    for (int i = 0; i < BEATS; i++) send_beat(BEAT_W'(i), 1'b0);
    chk("l0_wr_val", wr_val, 1'b1);
    chk("l0_addr", ram_wr_address, 0);
    chk_slot("l0_first", 0, ram_wr_data[BEAT_W-1:0], '0);
    chk_slot("l0_last", 7, ram_wr_data[LINE_W-1 -: BEAT_W], BEAT_W'(7));
    in_valid = 1'b0;
    step();
    chk("l0_occ", occupancy, 1);

    // Short line flushed by in_last.
    a_beat = {16{32'hA5A5_0001}};
    b_beat = {16{32'h5A5A_0002}};
    c_beat = {16{32'hC3C3_0003}};
    send_beat(a_beat, 1'b0);
    send_beat(b_beat, 1'b0);
    send_beat(c_beat, 1'b1);
    in_valid = 1'b0;
    chk("short_wr_val", wr_val, 1'b1);
    chk("short_addr", ram_wr_address, 1);
    chk_slot("short_a", 0, ram_wr_data[0 +: BEAT_W], a_beat);
    chk_slot("short_b", 1, ram_wr_data[BEAT_W +: BEAT_W], b_beat);
    chk_slot("short_c", 2, ram_wr_data[2*BEAT_W +: BEAT_W], c_beat);
    chk("short_zero", ram_wr_data[LINE_W-1:3*BEAT_W] == '0, 1'b1);
    step();
    chk("short_occ", occupancy, 2);
    send_beat(BEAT_W'(99), 1'b1);
    in_valid = 1'b0;
    chk("next_addr", ram_wr_address, 2);
    chk_slot("next_slot0", 0, ram_wr_data[0 +: BEAT_W], BEAT_W'(99));
    step();

    // Drain, then a consume at zero occupancy is ignored.
    repeat (3) consume_one();
    chk("drain_occ", occupancy, 0);
    chk("drain_rd", ram_rd_address, 3);
    consume_one();
    chk("empty_consume_occ", occupancy, 0);
    chk("empty_consume_rd", ram_rd_address, 3);

    // Consume coincident with a write at occupancy 5.
    for (int k = 0; k < 5; k++) send_line(16 * k);
    step();
    chk("five_occ", occupancy, 5);
    for (int i = 0; i < BEATS; i++) send_beat(BEAT_W'(300 + i), 1'b0);
    in_valid = 1'b0;
    line_consumed = 1'b1;
    step();
    line_consumed = 1'b0;
    chk("coinc_occ", occupancy, 5);
    chk("coinc_rd", ram_rd_address, 4);

    // Fill all 128 lines, then free one.
    do_reset();
    for (int k = 0; k < DEPTH; k++) send_line(k);
    step();
    chk("full_flag", full, 1'b1);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_occ", occupancy, DEPTH);
    consume_one();
    chk("unstall_in_ready", in_ready, 1'b1);
    chk("unstall_rd", ram_rd_address, 1);
    chk("unstall_full", full, 1'b0);

    // 130 lines with consumption after each: address wraps, occupancy stays <= 1.
    do_reset();
    for (int k = 0; k < DEPTH + 2; k++) begin
      for (int i = 0; i < BEATS; i++) send_beat(BEAT_W'(k), 1'b0);
      in_valid = 1'b0;
      chk("wrap_addr", ram_wr_address, k % DEPTH);
      step();
      chk("wrap_occ_max", occupancy <= 1, 1'b1);
      consume_one();
      chk("wrap_occ_after", occupancy, 0);
    end

    // Reset mid-line discards the partial line.
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(BEAT_W'(50 + i), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst_wr_val0", wr_val, 1'b0);
    step();
    chk("midrst_wr_val1", wr_val, 1'b0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < BEATS; i++) send_beat(BEAT_W'(200 + i), 1'b0);
    in_valid = 1'b0;
    chk("midrst_wr_val", wr_val, 1'b1);
    chk("midrst_addr", ram_wr_address, 0);
    for (int s = 0; s < BEATS; s++)
      chk_slot("midrst_data", s, ram_wr_data[s*BEAT_W +: BEAT_W], BEAT_W'(200 + s));
    step();

    // Random traffic: slow consumer (reaches full), then fast consumer.
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 3000; c++) begin
        in_valid      = ($urandom_range(0, 9) < 7);
        in_data       = rand_beat();
        in_last       = ($urandom_range(0, 9) == 0);
        line_consumed = (phase == 0) ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 9) < 5);
        rst           = ($urandom_range(0, 999) == 0);
        step();
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    line_consumed = 1'b0;
    rst = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_line_packer.md
RAM_LINE_PACKER -- requirements
Module: ram_line_packer

Interface
REQ-001 The parameter BEAT_W SHALL default to 512 and set the input beat width in bits.
REQ-002 The parameter BEATS SHALL default to 8 and set the number of beats per RAM line; RAM line width = BEAT_W*BEATS = 4096.
REQ-003 The parameter DEPTH SHALL default to 128 and set the number of RAM lines; ADDR_W = 7.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_data  input  BEAT_W  input beat.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_last  input  1  qualifies the accepted beat as the final beat of a partial line (flush).
REQ-010 in_ready  output  1  the block accepts a beat when in_valid && in_ready.
REQ-011 ram_wr_address  output  ADDR_W  RAM write line index.
REQ-012 ram_wr_data  output  4096  assembled line.
REQ-013 wr_val  output  1  one-cycle RAM write strobe.
REQ-014 ram_rd_address  output  ADDR_W  line index the consumer reads next.
REQ-015 line_consumed  input  1  consumer pulse: the line at ram_rd_address is freed.
REQ-016 occupancy  output  ADDR_W+1  written, unconsumed lines (0..DEPTH).
REQ-017 full  output  1  occupancy == DEPTH.

Function
REQ-018 FSM states: FILL, WRITE, STALL.
REQ-019 In FILL, in_ready SHALL be 1; each accepted beat SHALL be stored in slot beat_cnt, occupying bits [beat_cnt*BEAT_W +: BEAT_W], and beat_cnt SHALL increment.
REQ-020 Accepting beat BEATS-1, or any beat with in_last=1, SHALL move FILL -> WRITE; slots not written in that line SHALL be zero.
REQ-021 In WRITE (exactly one cycle): wr_val=1, ram_wr_address=wr_ptr, ram_wr_data=assembled line, in_ready=0; then the block SHALL increment wr_ptr modulo DEPTH, clear beat_cnt and the slot buffer, and increment occupancy.
REQ-022 Latency: final beat accepted at cycle N -> wr_val high at cycle N+1; sustained throughput is BEATS beats per BEATS+1 cycles.
REQ-023 WRITE SHALL go to STALL if the post-write occupancy equals DEPTH, otherwise to FILL.
REQ-024 In STALL, in_ready SHALL be 0; the block SHALL return to FILL in the cycle after occupancy drops below DEPTH.
REQ-025 line_consumed with occupancy > 0 SHALL increment ram_rd_address modulo DEPTH and decrement occupancy; with occupancy == 0 it SHALL be ignored.
REQ-026 A line_consumed in the same cycle as a WRITE SHALL leave occupancy unchanged while both pointers advance.
REQ-027 wr_ptr and ram_rd_address SHALL wrap from 127 to 0.
REQ-028 When wr_val=0, ram_wr_address and ram_wr_data SHALL be don't-care for the consumer; wr_val SHALL be 0 in every state except WRITE.
REQ-029 in_last on a beat that completes a full line SHALL behave identically to a plain full line.

Reset
REQ-030 rst SHALL force the state to FILL, wr_ptr=0, ram_rd_address=0, occupancy=0, full=0, wr_val=0, beat_cnt=0, and slot buffer=0.
REQ-031 in_ready SHALL be 0 during any cycle in which rst is high, and 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-line SHALL discard the partial line without issuing any write.

Structure
REQ-033 The package ram_pkg SHALL hold BEAT_W, BEATS, DEPTH, ADDR_W, LINE_W=4096, and the FSM state enum.
REQ-034 The slot buffer and beat counter SHALL be the sub-module ram_line_assembler; the FSM and pointers SHALL stay in the top level.

Verification
REQ-035 Back-to-back 8 beats of values 0..7 -> one wr_val at address 0, cycle N+1; line bits [511:0]=0 and [4095:3584]=7; occupancy=1.
REQ-036 3 beats A,B,C with in_last set on C -> write with slots 0..2 = A,B,C and slots 3..7 = 0; next line starts at slot 0, address 1.
REQ-037 128 lines with no consumption -> full=1 and in_ready=0; one line_consumed -> in_ready=1 the cycle after; ram_rd_address=1.
REQ-038 Write 130 lines while consuming each line after it is written -> ram_wr_address sequence wraps 127 -> 0 -> 1; occupancy never exceeds 1.
REQ-039 line_consumed coincident with WRITE at occupancy 5 -> occupancy stays 5; line_consumed at occupancy 0 -> no change.
REQ-040 rst asserted after 4 of 8 beats -> no wr_val; after release, 8 new beats produce a write at address 0 with no stale data.
